// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and helpers for the convolution sequencers.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  function automatic int conv_out_dim(input int mapsize, input int ksize, input int stride);
    return (mapsize - ksize) / stride + 1;
  endfunction

  // Callers sign-extend to 64 bits and truncate the result back to their width.
  function automatic logic signed [63:0] relu(input logic signed [63:0] acc);
    return (acc < 0) ? '0 : acc;
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed DW x DW multiply with wrapping ACCW accumulate; clr has priority over en.
module conv_mac #(
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_q, acc_d;

  assign prod  = a * b;
  assign acc_d = clr ? '0 : en ? acc_q + ACCW'(prod) : acc_q;
  assign acc   = acc_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
endmodule

// File: rtl/conv_stream_sequencer.sv
// conv_stream_sequencer: strided KxK multi-channel convolution walker streaming pixels on valid/ready.
// Define CONV_RELU_EN to clamp negative results to zero on out_data (accumulator untouched).
module conv_stream_sequencer
  import conv_pkg::*;
#(
  parameter int MAPSIZE  = 32,
  parameter int KSIZE    = 5,
  parameter int STRIDE   = 1,
  parameter int CHANNELS = 1,
  parameter int DW       = 8,
  parameter int ACCW     = 32,
  localparam int OUTDIM  = conv_out_dim(MAPSIZE, KSIZE, STRIDE),
  localparam int TAPS    = CHANNELS * KSIZE * KSIZE,
  localparam int FM_AW   = $clog2(CHANNELS * MAPSIZE * MAPSIZE),
  localparam int W_AW    = $clog2(TAPS),
  localparam int OUT_AW  = $clog2(OUTDIM * OUTDIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [FM_AW-1:0]       fm_addr,
  input  logic signed [DW-1:0]   fm_rdata,
  output logic [W_AW-1:0]        w_addr,
  input  logic signed [DW-1:0]   w_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_AW-1:0]      out_addr,
  output logic signed [ACCW-1:0] out_data
);
  localparam int OW = $clog2(OUTDIM) + 1;
  localparam int KW = $clog2(KSIZE) + 1;
  localparam int CW = $clog2(CHANNELS) + 1;

  if ((MAPSIZE - KSIZE) % STRIDE != 0) $error("window does not tile the map with this STRIDE");
  if (KSIZE > MAPSIZE) $error("KSIZE exceeds MAPSIZE");
  if (ACCW < 2 * DW) $error("ACCW narrower than a full product");

  state_t state_q, state_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [KW-1:0] i_q, i_d, j_q, j_d;
  logic [CW-1:0] c_q, c_d;
  logic rd_q, tap0, last_j, last_i, last_c, last_tap, last_ox, last_px;
  logic [FM_AW-1:0] fm_a;
  logic [W_AW-1:0] w_a;
  logic signed [ACCW-1:0] acc, res;

  assign last_j   = j_q == KW'(KSIZE - 1);
  assign last_i   = i_q == KW'(KSIZE - 1);
  assign last_c   = c_q == CW'(CHANNELS - 1);
  assign last_tap = last_c && last_i && last_j;
  assign last_ox  = ox_q == OW'(OUTDIM - 1);
  assign last_px  = last_ox && oy_q == OW'(OUTDIM - 1);
  assign tap0     = state_q == FETCH && c_q == '0 && i_q == '0 && j_q == '0;

  assign fm_a = FM_AW'(int'(c_q) * MAPSIZE * MAPSIZE + (int'(oy_q) * STRIDE + int'(i_q)) * MAPSIZE
                       + int'(ox_q) * STRIDE + int'(j_q));
  assign w_a  = W_AW'(int'(c_q) * KSIZE * KSIZE + int'(i_q) * KSIZE + int'(j_q));

`ifdef CONV_RELU_EN
  assign res = ACCW'(relu(64'(acc)));
`else
  assign res = acc;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rd_q    <= state_q == FETCH;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = last_tap ? DRAIN : FETCH;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = !out_ready ? WRITE : last_px ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap counters wrap back to zero on the last tap, so each pixel starts at tap 0.
  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
    c_d  = c_q;
    i_d  = i_q;
    j_d  = j_q;
    if (state_q == IDLE && start) begin
      ox_d = '0;
      oy_d = '0;
    end
    if (state_q == FETCH) begin
      j_d = last_j ? '0 : j_q + 1'b1;
      i_d = !last_j ? i_q : last_i ? '0 : i_q + 1'b1;
      c_d = !(last_j && last_i) ? c_q : last_c ? '0 : c_q + 1'b1;
    end
    if (state_q == WRITE && out_ready && !last_px) begin
      ox_d = last_ox ? '0 : ox_q + 1'b1;
      oy_d = last_ox ? oy_q + 1'b1 : oy_q;
    end
  end

  always_comb begin
    busy      = state_q == FETCH || state_q == DRAIN || state_q == WRITE;
    done      = state_q == DONE;
    mem_rd_en = state_q == FETCH;
    out_valid = state_q == WRITE;
    fm_addr   = state_q == FETCH ? fm_a : '0;
    w_addr    = state_q == FETCH ? w_a : '0;
    out_addr  = state_q == WRITE ? OUT_AW'(int'(oy_q) * OUTDIM + int'(ox_q)) : '0;
    out_data  = state_q == WRITE ? res : '0;
  end

  // Read data lands one cycle after issue, so the add is enabled by the delayed strobe.
  conv_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (tap0),
    .en  (rd_q),
    .a   (fm_rdata),
    .b   (w_rdata),
    .acc (acc)
  );
endmodule

// File: tb/tb_conv_stream_sequencer.sv
// tb_conv_stream_sequencer: scoreboard bench over three configurations of the sequencer.
module tb_conv_stream_sequencer;
  typedef struct {int a; int d;} exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int na = 0, nb = 0, nc = 0;
  exp_t qa[$], qb[$], qc[$];
  logic signed [7:0] fa = '0, wa = '0, fc = '0, wc = '0;

  // A: MAPSIZE=8 KSIZE=3 STRIDE=1 CHANNELS=1
  logic sa = 1'b0, rdy_a = 1'b1, busy_a, done_a, rd_a, ov_a;
  logic [5:0] fm_a, oa_a;
  logic [3:0] w_a;
  logic signed [7:0] fd_a, wd_a;
  logic signed [31:0] od_a;
  // B: MAPSIZE=8 KSIZE=4 STRIDE=2 CHANNELS=2
  logic sb = 1'b0, rdy_b = 1'b1, busy_b, done_b, rd_b, ov_b;
  logic [6:0] fm_b;
  logic [4:0] w_b;
  logic [3:0] oa_b;
  logic signed [7:0] fd_b, wd_b;
  logic signed [31:0] od_b;
  // C: MAPSIZE=6 KSIZE=5 (default kernel), OUTDIM=2
  logic sc = 1'b0, rdy_c = 1'b1, busy_c, done_c, rd_c, ov_c;
  logic [5:0] fm_c;
  logic [4:0] w_c;
  logic [1:0] oa_c;
  logic signed [7:0] fd_c, wd_c;
  logic signed [31:0] od_c;

  conv_stream_sequencer #(.MAPSIZE(8), .KSIZE(3), .STRIDE(1), .CHANNELS(1)) dut_a (
    .clk(clk), .rst(rst), .start(sa), .busy(busy_a), .done(done_a), .mem_rd_en(rd_a),
    .fm_addr(fm_a), .fm_rdata(fd_a), .w_addr(w_a), .w_rdata(wd_a),
    .out_valid(ov_a), .out_ready(rdy_a), .out_addr(oa_a), .out_data(od_a));
  conv_stream_sequencer #(.MAPSIZE(8), .KSIZE(4), .STRIDE(2), .CHANNELS(2)) dut_b (
    .clk(clk), .rst(rst), .start(sb), .busy(busy_b), .done(done_b), .mem_rd_en(rd_b),
    .fm_addr(fm_b), .fm_rdata(fd_b), .w_addr(w_b), .w_rdata(wd_b),
    .out_valid(ov_b), .out_ready(rdy_b), .out_addr(oa_b), .out_data(od_b));
  conv_stream_sequencer #(.MAPSIZE(6)) dut_c (
    .clk(clk), .rst(rst), .start(sc), .busy(busy_c), .done(done_c), .mem_rd_en(rd_c),
    .fm_addr(fm_c), .fm_rdata(fd_c), .w_addr(w_c), .w_rdata(wd_c),
    .out_valid(ov_c), .out_ready(rdy_c), .out_addr(oa_c), .out_data(od_c));

  // Synchronous RAM models: uniform values for A and C, feature = row+col for B.
  always_ff @(posedge clk) begin
    if (rd_a) begin fd_a <= fa; wd_a <= wa; end
    if (rd_b) begin fd_b <= 8'((int'(fm_b) % 64) / 8 + int'(fm_b) % 8); wd_b <= 8'sd1; end
    if (rd_c) begin fd_c <= fc; wd_c <= wc; end
  end

  always @(negedge clk) if (ov_a && rdy_a) begin
    exp_t e;
    checks++; na++;
    if (qa.size() == 0) begin errors++; $display("FAIL a_extra addr=%0d data=%0d", oa_a, od_a); end
    else begin
      e = qa.pop_front();
      if (int'(oa_a) !== e.a || od_a !== 32'(e.d)) begin
        errors++; $display("FAIL a_pixel got addr=%0d data=%0d want addr=%0d data=%0d", oa_a, od_a, e.a, e.d);
      end
    end
  end
  always @(negedge clk) if (ov_b && rdy_b) begin
    exp_t e;
    checks++; nb++;
    if (qb.size() == 0) begin errors++; $display("FAIL b_extra addr=%0d data=%0d", oa_b, od_b); end
    else begin
      e = qb.pop_front();
      if (int'(oa_b) !== e.a || od_b !== 32'(e.d)) begin
        errors++; $display("FAIL b_pixel got addr=%0d data=%0d want addr=%0d data=%0d", oa_b, od_b, e.a, e.d);
      end
    end
  end
  always @(negedge clk) if (ov_c && rdy_c) begin
    exp_t e;
    checks++; nc++;
    if (qc.size() == 0) begin errors++; $display("FAIL c_extra addr=%0d data=%0d", oa_c, od_c); end
    else begin
      e = qc.pop_front();
      if (int'(oa_c) !== e.a || od_c !== 32'(e.d)) begin
        errors++; $display("FAIL c_pixel got addr=%0d data=%0d want addr=%0d data=%0d", oa_c, od_c, e.a, e.d);
      end
    end
  end

  function automatic int exp_relu(input int v);
`ifdef CONV_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic done_of(input int w);
    return w == 0 ? done_a : w == 1 ? done_b : done_c;
  endfunction

  function automatic logic busy_of(input int w);
    return w == 0 ? busy_a : w == 1 ? busy_b : busy_c;
  endfunction

  task automatic drive(input int w, input logic v);
    if (w == 0) sa = v;
    else if (w == 1) sb = v;
    else sc = v;
  endtask

  // Pulses start and returns n = cycle index of done (start cycle is 0), or -1 on timeout.
  task automatic kick(input int w, input int poke, output int n, output logic b1);
    @(posedge clk); #1 drive(w, 1'b1);
    @(posedge clk); #1 drive(w, 1'b0);
    n = 1;
    b1 = busy_of(w);
    while (!done_of(w) && n < 2000) begin
      @(posedge clk); #1 n++;
      drive(w, n == poke);
    end
    if (!done_of(w)) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, rd_a, ov_a} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {busy_a, done_a, rd_a, ov_a});
    end
    checks++;
    if (fm_a !== '0 || w_a !== '0) begin errors++; $display("FAIL reset_addr got fm=%0d w=%0d want 0", fm_a, w_a); end
    checks++;
    if (oa_a !== '0 || od_a !== '0) begin errors++; $display("FAIL reset_out got addr=%0d data=%0d want 0", oa_a, od_a); end
    rst = 1'b0;
  endtask

  task automatic test_uniform;
    int n;
    logic b1;
    fa = 8'sd1; wa = 8'sd2; na = 0;
    for (int k = 0; k < 36; k++) qa.push_back('{k, 18});
    kick(0, 0, n, b1);
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", b1); end
    checks++;
    if (n !== 1 + 36 * 11) begin errors++; $display("FAIL done_latency got %0d want %0d", n, 1 + 36 * 11); end
    checks++;
    if (na !== 36 || qa.size() !== 0) begin errors++; $display("FAIL uniform_count got %0d left %0d want 36 left 0", na, qa.size()); end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done_a, busy_a); end
  endtask

  task automatic test_backpressure;
    int k;
    int ev;
    ev = exp_relu(-27);
    fa = 8'sd3; wa = -8'sd1; na = 0; rdy_a = 1'b0;
    for (int p = 0; p < 36; p++) qa.push_back('{p, ev});
    @(posedge clk); #1 sa = 1'b1;
    @(posedge clk); #1 sa = 1'b0;
    k = 0;
    while (!ov_a && k < 100) begin @(posedge clk); #1 k++; end
    checks++;
    if (k !== 10) begin errors++; $display("FAIL first_write_latency got %0d want 10", k); end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      checks++;
      if (ov_a !== 1'b1 || oa_a !== '0 || od_a !== 32'(ev) || rd_a !== 1'b0) begin
        errors++; $display("FAIL stall_hold got valid=%b addr=%0d data=%0d rd=%b want 1 0 %0d 0", ov_a, oa_a, od_a, rd_a, ev);
      end
    end
    rdy_a = 1'b1;
    k = 0;
    while (!done_a && k < 1000) begin @(posedge clk); #1 k++; end
    checks++;
    if (!done_a || na !== 36 || qa.size() !== 0) begin
      errors++; $display("FAIL stall_resume got done=%b count=%0d left=%0d want 1 36 0", done_a, na, qa.size());
    end
  endtask

  task automatic test_reset_mid;
    int k;
    int n;
    logic b1;
    fa = 8'sd2; wa = 8'sd2; na = 0;
    for (int p = 0; p < 36; p++) qa.push_back('{p, 36});
    @(posedge clk); #1 sa = 1'b1;
    @(posedge clk); #1 sa = 1'b0;
    k = 0;
    while (na < 7 && k < 200) begin @(negedge clk); k++; end
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, rd_a, ov_a} !== 3'b0 || fm_a !== '0 || w_a !== '0 || od_a !== '0 || oa_a !== '0) begin
      errors++; $display("FAIL reset_mid got busy=%b rd=%b valid=%b fm=%0d w=%0d data=%0d want all 0", busy_a, rd_a, ov_a, fm_a, w_a, od_a);
    end
    checks++;
    if (qa.size() !== 29) begin errors++; $display("FAIL reset_mid_emitted got %0d left want 29", qa.size()); end
    qa.delete();
    @(posedge clk); #1 rst = 1'b0;
    k = 0;
    repeat (20) begin @(posedge clk); #1 if (ov_a || busy_a) k++; end
    checks++;
    if (k !== 0) begin errors++; $display("FAIL reset_quiet got %0d active cycles want 0", k); end
    na = 0;
    for (int p = 0; p < 36; p++) qa.push_back('{p, 36});
    kick(0, 0, n, b1);
    checks++;
    if (n !== 1 + 36 * 11 || na !== 36 || qa.size() !== 0) begin
      errors++; $display("FAIL rerun got cycles=%0d count=%0d want %0d 36", n, na, 1 + 36 * 11);
    end
  endtask

  task automatic test_start_busy;
    int n;
    int k;
    logic b1;
    fa = -8'sd2; wa = 8'sd5; na = 0;
    for (int p = 0; p < 36; p++) qa.push_back('{p, exp_relu(-90)});
    kick(0, 50, n, b1);
    checks++;
    if (n !== 1 + 36 * 11 || na !== 36 || qa.size() !== 0) begin
      errors++; $display("FAIL start_busy got cycles=%0d count=%0d want %0d 36", n, na, 1 + 36 * 11);
    end
    sa = 1'b1;
    @(posedge clk); #1 sa = 1'b0;
    k = 0;
    repeat (5) begin @(posedge clk); #1 if (busy_a || rd_a) k++; end
    checks++;
    if (k !== 0) begin errors++; $display("FAIL start_in_done got %0d busy cycles want 0", k); end
  endtask

  task automatic test_multichannel;
    int n;
    logic b1;
    nb = 0;
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++) qb.push_back('{oy * 3 + ox, 64 * (ox + oy) + 96});
    kick(1, 0, n, b1);
    checks++;
    if (n !== 1 + 9 * 34 || nb !== 9 || qb.size() !== 0) begin
      errors++; $display("FAIL multichannel got cycles=%0d count=%0d want %0d 9", n, nb, 1 + 9 * 34);
    end
  endtask

  task automatic test_relu;
    int n;
    logic b1;
    fc = -8'sd1; wc = 8'sd1; nc = 0;
    for (int p = 0; p < 4; p++) qc.push_back('{p, exp_relu(-25)});
    kick(2, 0, n, b1);
    checks++;
    if (n !== 1 + 4 * 27 || nc !== 4 || qc.size() !== 0) begin
      errors++; $display("FAIL relu_run got cycles=%0d count=%0d want %0d 4", n, nc, 1 + 4 * 27);
    end
  endtask

  task automatic test_wide;
    int n;
    logic b1;
    fc = 8'sd127; wc = 8'sh80; nc = 0;
    for (int p = 0; p < 4; p++) qc.push_back('{p, exp_relu(-406400)});
    kick(2, 0, n, b1);
    checks++;
    if (nc !== 4 || qc.size() !== 0 || n < 0) begin
      errors++; $display("FAIL wide_run got count=%0d left=%0d cycles=%0d want 4 0", nc, qc.size(), n);
    end
  endtask

  initial begin
    test_reset;
    test_uniform;
    test_backpressure;
    test_reset_mid;
    test_start_busy;
    test_multichannel;
    test_relu;
    test_wide;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_stream_sequencer.md
Name: conv_stream_sequencer

Overview:
- Parametrised successor to the fixed 5x5 single-channel convolution controller.
- Walks a KSIZE x KSIZE window over a CHANNELS-deep feature map held in external RAM, using a configurable STRIDE.
- Fetches feature and weight taps through synchronous read ports and accumulates over all channels with an internal MAC.
- Streams each output pixel on a valid/ready port, so the next layer's buffer can apply back-pressure.

Parameters:
- MAPSIZE, 32: input feature map height = width.
- KSIZE, 5: kernel height = width; KSIZE <= MAPSIZE.
- STRIDE, 1: window step in x and y; (MAPSIZE-KSIZE) % STRIDE == 0, checked by elaboration assertion.
- CHANNELS, 1: input channels summed into each output pixel.
- DW, 8: signed feature/weight width.
- ACCW, 32: signed accumulator/output width; ACCW >= 2*DW.
- Derived localparams:
  - OUTDIM = (MAPSIZE-KSIZE)/STRIDE+1
  - TAPS = CHANNELS*KSIZE*KSIZE
  - FM_AW = $clog2(CHANNELS*MAPSIZE*MAPSIZE)
  - W_AW = $clog2(TAPS)
  - OUT_AW = $clog2(OUTDIM*OUTDIM)

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last output handshake.
- mem_rd_en  out  1  read strobe shared by the feature and weight RAMs.
- fm_addr  out  FM_AW  feature address = c*MAPSIZE^2 + row*MAPSIZE + col.
- fm_rdata  in  DW  signed feature data, valid the cycle after mem_rd_en.
- w_addr  out  W_AW  weight address = c*KSIZE^2 + i*KSIZE + j.
- w_rdata  in  DW  signed weight data, valid the cycle after mem_rd_en.
- out_valid  out  1  out_data/out_addr hold a result.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_addr  out  OUT_AW  oy*OUTDIM + ox.
- out_data  out  ACCW  signed result.

Behaviour:
- Reset (async, any state): state=IDLE; ox, oy, tap counters = 0; accumulator = 0. busy, done, mem_rd_en, out_valid = 0; fm_addr, w_addr, out_addr, out_data = 0. An in-flight pixel is discarded, never emitted.
- States and transitions:
  - IDLE: start=1 -> FETCH; ox=oy=0.
  - FETCH: one tap per cycle, t = 0..TAPS-1, ordered c outer, i, then j inner. mem_rd_en=1 with both addresses valid. Tap (c,i,j) reads row = oy*STRIDE+i, col = ox*STRIDE+j. After t = TAPS-1 -> DRAIN.
  - DRAIN: mem_rd_en=0; absorbs the final product -> WRITE.
  - WRITE: out_valid=1, out_data = accumulator (optional ReLU applied), out_addr = oy*OUTDIM+ox. Held stable until out_ready.
    - On handshake, if ox==OUTDIM-1 && oy==OUTDIM-1 -> DONE.
    - Otherwise advance ox (wrap to 0 and increment oy at ox==OUTDIM-1) -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- MAC:
  - Accumulator is cleared in the cycle tap 0 is issued.
  - Each product fm_rdata*w_rdata (signed, 2*DW bits) is sign-extended to ACCW and added one cycle after its issue.
  - Overflow wraps two's-complement; no saturation.
- Latency: TAPS+2 cycles per pixel with out_ready held high. Full map = OUTDIM^2 * (TAPS+2) cycles, plus 1 cycle for DONE.
- Edge cases:
  - start while busy or in DONE: ignored.
  - start and reset together: reset wins.
  - out_ready high outside WRITE: no effect.
  - out_ready low: FSM stalls in WRITE; no reads are issued.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: out_data = (acc < 0) ? 0 : acc. The accumulator itself is unchanged.
- Undefined: out_data = acc, raw signed value.
- Timing and cycle counts are identical in both builds.

Decomposition:
- Package conv_pkg:
  - state_t enum {IDLE, FETCH, DRAIN, WRITE, DONE}.
  - function conv_out_dim(mapsize, ksize, stride).
  - function relu(acc).
- Sub-module conv_mac: signed DW x DW multiply, ACCW accumulate; inputs clr, en, a, b; output acc. Reused by later pooling/FC sequencers.

Test Plan:
- Config MAPSIZE=8, KSIZE=3, STRIDE=1, CHANNELS=1; all features 1, all weights 2, out_ready=1 -> 36 outputs of 18, out_addr 0..35 in order, done 1 + 36*11 cycles after start.
- Config MAPSIZE=8, KSIZE=4, STRIDE=2, CHANNELS=2; feature[c][r][col] = r+col, weights = 1 -> OUTDIM=3. Output at (ox,oy) = 2*(16*(oy+ox)*2 + 48) = 64*(ox+oy) + 96. First three outputs 96, 160, 224.
- Features all -1, weights all 1, default params: without CONV_RELU_EN every out_data = -25; with CONV_RELU_EN every out_data = 0.
- out_ready held low for 5 cycles on the first WRITE -> out_valid, out_data, out_addr stable; mem_rd_en=0 throughout; after release the next pixel proceeds normally.
- Reset asserted mid-FETCH of pixel 7 -> all outputs 0 immediately; no out_valid until a new start; rerun from pixel 0 gives correct results.
- start pulsed during busy -> ignored; total output count and done timing unchanged. Feature 127 * weight -128 over 25 taps -> out_data = -406400, confirming no wrap at ACCW=32.
